// File: rtl/equiv_pkg.sv
// Shared definitions for the equivalence checker: run-state encoding.
package equiv_pkg;

   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/equiv_checker_hold_timer.sv
// Hold-window timer: counts 0..HOLD-1 while enabled and flags the last cycle.
module hold_timer #(
   parameter int HOLD = 10
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic tick
);

   localparam int            CW   = (HOLD > 1) ? $clog2(HOLD) : 1;
   localparam logic [CW-1:0] LAST = CW'(HOLD - 1);

   logic [CW-1:0] count_r;

   // Hold counter: cleared outside a run, wraps after the last cycle of each window.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_r <= '0;
      end else if (clear) begin
         count_r <= '0;
      end else if (enable) begin
         if (count_r == LAST) begin
            count_r <= '0;
         end else begin
            count_r <= count_r + CW'(1);
         end
      end else begin
         count_r <= count_r;
      end
   end

   assign tick = (count_r == LAST);

endmodule

// File: rtl/equiv_checker.sv
// Equivalence checker: sweeps every input vector, holds each for HOLD cycles,
// compares two responses at the end of each window and summarises the run.
module equiv_checker
   import equiv_pkg::*;
#(
   parameter int N_IN  = 2,
   parameter int HOLD  = 10,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic [N_IN-1:0]  vec_out,
   input  logic             resp_a,
   input  logic             resp_b,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] err_count,
   output logic [N_IN-1:0]  first_err_vec,
   output logic             first_err_valid
);

   localparam logic [CNT_W-1:0] ERR_MAX  = '1;
   localparam logic [N_IN-1:0]  VEC_LAST = '1;

   state_t           state_r;
   logic [N_IN-1:0]  vec_r;
   logic             busy_r;
   logic             done_r;
   logic             pass_r;
   logic [CNT_W-1:0] err_r;
   logic [N_IN-1:0]  first_vec_r;
   logic             first_valid_r;

   logic             tick_s;
   logic             in_run_s;
   logic             sample_s;
   logic             mismatch_s;
   logic [CNT_W-1:0] err_next_s;

   assign in_run_s   = (state_r == ST_RUN);
   assign sample_s   = in_run_s && tick_s;
   assign mismatch_s = (resp_a != resp_b);

   hold_timer #(
      .HOLD (HOLD)
   ) u_hold_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (!in_run_s),
      .enable (in_run_s),
      .tick   (tick_s)
   );

   // Saturating next value of the mismatch counter for the current sample.
   always_comb begin
      err_next_s = err_r;
      if (sample_s && mismatch_s && (err_r != ERR_MAX)) begin
         err_next_s = err_r + CNT_W'(1);
      end else begin
         err_next_s = err_r;
      end
   end

   // Run FSM with vector register, counter, first-failure capture and status flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= ST_IDLE;
         vec_r         <= '0;
         busy_r        <= 1'b0;
         done_r        <= 1'b0;
         pass_r        <= 1'b0;
         err_r         <= '0;
         first_vec_r   <= '0;
         first_valid_r <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state_r       <= ST_RUN;
                  vec_r         <= '0;
                  busy_r        <= 1'b1;
                  done_r        <= 1'b0;
                  pass_r        <= 1'b0;
                  err_r         <= '0;
                  first_vec_r   <= '0;
                  first_valid_r <= 1'b0;
               end else begin
                  state_r <= state_r;
               end
            end
            ST_RUN: begin
               if (sample_s) begin
                  err_r <= err_next_s;
                  if (mismatch_s && !first_valid_r) begin
                     first_vec_r   <= vec_r;
                     first_valid_r <= 1'b1;
                  end else begin
                     first_valid_r <= first_valid_r;
                  end
                  if (vec_r == VEC_LAST) begin
                     // Final window closed: the last sample is already folded into pass.
                     state_r <= ST_DONE;
                     busy_r  <= 1'b0;
                     done_r  <= 1'b1;
                     pass_r  <= (err_next_s == '0);
                  end else begin
                     vec_r <= vec_r + N_IN'(1);
                  end
               end else begin
                  state_r <= ST_RUN;
               end
            end
            default: begin
               state_r       <= ST_IDLE;
               vec_r         <= '0;
               busy_r        <= 1'b0;
               done_r        <= 1'b0;
               pass_r        <= 1'b0;
               err_r         <= '0;
               first_vec_r   <= '0;
               first_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign vec_out         = vec_r;
   assign busy            = busy_r;
   assign done            = done_r;
   assign pass            = pass_r;
   assign err_count       = err_r;
   assign first_err_vec   = first_vec_r;
   assign first_err_valid = first_valid_r;

endmodule
